// File: rtl/branch_resolve_unit.sv
// Purpose: resolves branches/jumps in EXEC, holds the redirect through the delay slots, then hands it to the PC.
// Latency: link/nested_err/annul 1 cycle after exec_valid; redirect 1 cycle after the last counted slot_retire.
// Backpressure: redirect_valid/target held stable until redirect_ready; branches arriving while busy are dropped (nested_err).
// Optional feature: `define BRANCH_LIKELY_EN to decode branch-likely forms and drive annul.
module branch_resolve_unit #(
    parameter int ADDR_W      = 32,
    parameter int DELAY_SLOTS = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              exec_valid,
    input  logic [31:0]       instr,
    input  logic [ADDR_W-1:0] pc,
    input  logic [31:0]       rs_val,
    input  logic [31:0]       rt_val,
    input  logic              slot_retire,
    output logic              redirect_valid,
    output logic [ADDR_W-1:0] redirect_target,
    input  logic              redirect_ready,
    output logic              link_we,
    output logic [4:0]        link_reg,
    output logic [31:0]       link_data,
    output logic              busy,
    output logic              nested_err,
    output logic              annul
);

    localparam int CW = $clog2(DELAY_SLOTS + 1);
    localparam logic [ADDR_W-1:0] J_LOW_MASK = ADDR_W'(32'h0FFF_FFFF);

    typedef enum logic [1:0] {IDLE, COUNT, REDIRECT} state_t;

    state_t          state;
    logic [CW-1:0]   count;

    logic [5:0]        opcode;
    logic [4:0]        rt_field;
    logic [5:0]        funct;
    logic              ops_eq;
    logic              rs_neg;
    logic              rs_zero;
    logic [ADDR_W-1:0] pc4;
    logic [ADDR_W-1:0] br_off;
    logic [ADDR_W-1:0] br_target;
    logic [ADDR_W-1:0] j_target;
    logic [ADDR_W-1:0] jr_target;
    logic [ADDR_W-1:0] link_addr;
    logic [ADDR_W-1:0] next_target;

    logic              is_branch;
    logic              is_taken;
    logic              is_link;
    logic              tgt_jump;
    logic              tgt_reg;
    logic [4:0]        link_rd;
`ifdef BRANCH_LIKELY_EN
    logic              is_likely;
`endif

    assign opcode    = instr[31:26];
    assign rt_field  = instr[20:16];
    assign funct     = instr[5:0];
    assign ops_eq    = (rs_val == rt_val);
    assign rs_neg    = rs_val[31];
    assign rs_zero   = (rs_val == 32'd0);
    assign pc4       = pc + ADDR_W'(4);
    assign br_off    = {{(ADDR_W-18){instr[15]}}, instr[15:0], 2'b00};
    assign br_target = pc4 + br_off;
    assign j_target  = (pc4 & ~J_LOW_MASK) | ADDR_W'({instr[25:0], 2'b00});
    assign jr_target = ADDR_W'(rs_val);
    // return address skips the branch and all of its delay slots
    assign link_addr = pc + ADDR_W'(4 * (DELAY_SLOTS + 1));
    assign next_target = tgt_reg ? jr_target : (tgt_jump ? j_target : br_target);

    // decode branch class, taken condition (full signed compares) and link destination
    always_comb begin
        is_branch = 1'b0;
        is_taken  = 1'b0;
        is_link   = 1'b0;
        tgt_jump  = 1'b0;
        tgt_reg   = 1'b0;
        link_rd   = 5'd31;
`ifdef BRANCH_LIKELY_EN
        is_likely = 1'b0;
`endif
        case (opcode)
            6'h00: begin
                if (funct == 6'h08 || funct == 6'h09) begin
                    is_branch = 1'b1;
                    is_taken  = 1'b1;
                    tgt_reg   = 1'b1;
                    if (funct == 6'h09) begin
                        is_link = 1'b1;
                        link_rd = instr[15:11];
                    end
                end
            end
            6'h01: begin
                case (rt_field)
                    5'h00: begin is_branch = 1'b1; is_taken = rs_neg;  end
                    5'h01: begin is_branch = 1'b1; is_taken = !rs_neg; end
                    5'h10: begin is_branch = 1'b1; is_taken = rs_neg;  is_link = 1'b1; end
                    5'h11: begin is_branch = 1'b1; is_taken = !rs_neg; is_link = 1'b1; end
`ifdef BRANCH_LIKELY_EN
                    5'h02: begin is_branch = 1'b1; is_likely = 1'b1; is_taken = rs_neg;  end
                    5'h03: begin is_branch = 1'b1; is_likely = 1'b1; is_taken = !rs_neg; end
                    5'h12: begin is_branch = 1'b1; is_likely = 1'b1; is_taken = rs_neg;  is_link = 1'b1; end
                    5'h13: begin is_branch = 1'b1; is_likely = 1'b1; is_taken = !rs_neg; is_link = 1'b1; end
`endif
                    default: ;
                endcase
            end
            6'h02: begin is_branch = 1'b1; is_taken = 1'b1; tgt_jump = 1'b1; end
            6'h03: begin is_branch = 1'b1; is_taken = 1'b1; tgt_jump = 1'b1; is_link = 1'b1; end
            6'h04: begin is_branch = 1'b1; is_taken = ops_eq; end
            6'h05: begin is_branch = 1'b1; is_taken = !ops_eq; end
            6'h06: begin is_branch = 1'b1; is_taken = rs_neg || rs_zero; end
            6'h07: begin is_branch = 1'b1; is_taken = !(rs_neg || rs_zero); end
`ifdef BRANCH_LIKELY_EN
            6'h14: begin is_branch = 1'b1; is_likely = 1'b1; is_taken = ops_eq; end
            6'h15: begin is_branch = 1'b1; is_likely = 1'b1; is_taken = !ops_eq; end
            6'h16: begin is_branch = 1'b1; is_likely = 1'b1; is_taken = rs_neg || rs_zero; end
            6'h17: begin is_branch = 1'b1; is_likely = 1'b1; is_taken = !(rs_neg || rs_zero); end
`endif
            default: ;
        endcase
    end

    // redirect FSM with registered handshake, link and error outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state           <= IDLE;
            count           <= '0;
            redirect_valid  <= 1'b0;
            redirect_target <= '0;
            link_we         <= 1'b0;
            link_reg        <= 5'd0;
            link_data       <= 32'd0;
            busy            <= 1'b0;
            nested_err      <= 1'b0;
        end else begin
            link_we    <= 1'b0;
            nested_err <= 1'b0;
            case (state)
                IDLE: begin
                    // a slot_retire this cycle belongs to an older instruction and is not counted
                    if (exec_valid && is_branch) begin
                        if (is_link) begin
                            link_we   <= 1'b1;
                            link_reg  <= link_rd;
                            link_data <= 32'(link_addr);
                        end
                        if (is_taken) begin
                            redirect_target <= next_target;
                            count           <= CW'(DELAY_SLOTS);
                            busy            <= 1'b1;
                            state           <= COUNT;
                        end
                    end
                end
                COUNT: begin
                    if (exec_valid && is_branch) nested_err <= 1'b1;
                    if (slot_retire) begin
                        count <= count - CW'(1);
                        if (count == CW'(1)) begin
                            redirect_valid <= 1'b1;
                            state          <= REDIRECT;
                        end
                    end
                end
                REDIRECT: begin
                    if (exec_valid && is_branch) nested_err <= 1'b1;
                    if (redirect_ready) begin
                        redirect_valid <= 1'b0;
                        busy           <= 1'b0;
                        state          <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef BRANCH_LIKELY_EN
    // annul pulse for a not-taken likely branch accepted in IDLE
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) annul <= 1'b0;
        else          annul <= exec_valid && (state == IDLE) && is_branch && is_likely && !is_taken;
    end
`else
    assign annul = 1'b0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
module tb_branch_resolve_unit;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic [1:0]  ev;
    logic [31:0] instr, pc, rs_val, rt_val;
    logic        slot_retire, redirect_ready;

    logic        rv1, lwe1, bz1, ne1, an1;
    logic [31:0] tg1, ld1;
    logic [4:0]  lr1;
    logic        rv3, lwe3, bz3, ne3, an3;
    logic [31:0] tg3, ld3;
    logic [4:0]  lr3;

    logic [73:0] ov1, ov3;
    assign ov1 = {rv1, tg1, lwe1, lr1, ld1, bz1, ne1, an1};
    assign ov3 = {rv3, tg3, lwe3, lr3, ld3, bz3, ne3, an3};

    int n_tests = 0;
    int n_fail  = 0;

`ifdef BRANCH_LIKELY_EN
    localparam bit LIKELY_EN = 1'b1;
`else
    localparam bit LIKELY_EN = 1'b0;
`endif

    branch_resolve_unit #(.ADDR_W(32), .DELAY_SLOTS(1)) u_ds1 (
        .clk(clk), .reset_n(reset_n), .exec_valid(ev[0]), .instr(instr), .pc(pc),
        .rs_val(rs_val), .rt_val(rt_val), .slot_retire(slot_retire),
        .redirect_valid(rv1), .redirect_target(tg1), .redirect_ready(redirect_ready),
        .link_we(lwe1), .link_reg(lr1), .link_data(ld1), .busy(bz1),
        .nested_err(ne1), .annul(an1));

    branch_resolve_unit #(.ADDR_W(32), .DELAY_SLOTS(3)) u_ds3 (
        .clk(clk), .reset_n(reset_n), .exec_valid(ev[1]), .instr(instr), .pc(pc),
        .rs_val(rs_val), .rt_val(rt_val), .slot_retire(slot_retire),
        .redirect_valid(rv3), .redirect_target(tg3), .redirect_ready(redirect_ready),
        .link_we(lwe3), .link_reg(lr3), .link_data(ld3), .busy(bz3),
        .nested_err(ne3), .annul(an3));

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rt, input logic [15:0] imm);
        return {op, 5'd1, rt, imm};
    endfunction

    function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] idx);
        return {op, idx};
    endfunction

    function automatic logic [31:0] enc_r(input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, 5'd1, 5'd2, rd, 5'd0, fn};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ev = 2'b00; instr = 32'd0; pc = 32'd0; rs_val = 32'd0; rt_val = 32'd0;
        slot_retire = 1'b0; redirect_ready = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset_n = 1'b0;
        #2;
        n_tests++; if (ov1 !== 74'd0) begin n_fail++; $display("FAIL reset_ds1: got %h want 0", ov1); end
        n_tests++; if (ov3 !== 74'd0) begin n_fail++; $display("FAIL reset_ds3: got %h want 0", ov3); end
        tick();
        reset_n = 1'b1;
    endtask

    task automatic test_beq();
        do_reset();
        instr = enc_i(6'h04, 5'd2, 16'h0004); pc = 32'h100; rs_val = 5; rt_val = 5;
        ev = 2'b01; slot_retire = 1'b1;   // same-cycle retire must not be counted
        tick();
        n_tests++; if (bz1 !== 1'b1) begin n_fail++; $display("FAIL beq_busy: got %b want 1", bz1); end
        n_tests++; if (rv1 !== 1'b0) begin n_fail++; $display("FAIL beq_early_valid: got %b want 0", rv1); end
        ev = 2'b00; slot_retire = 1'b1; redirect_ready = 1'b1;
        tick();
        n_tests++; if (rv1 !== 1'b1) begin n_fail++; $display("FAIL beq_valid: got %b want 1", rv1); end
        n_tests++; if (tg1 !== 32'h114) begin n_fail++; $display("FAIL beq_target: got %h want 114", tg1); end
        slot_retire = 1'b0;
        tick();
        n_tests++; if ({rv1, bz1} !== 2'b00) begin n_fail++; $display("FAIL beq_release: got %b want 00", {rv1, bz1}); end
        redirect_ready = 1'b0;
    endtask

    task automatic test_bgezal();
        do_reset();
        instr = enc_i(6'h01, 5'h11, 16'h0010); pc = 32'h200; rs_val = 32'hFFFF_FFFF;
        ev = 2'b01;
        tick();
        n_tests++; if ({lwe1, lr1} !== {1'b1, 5'd31}) begin n_fail++; $display("FAIL bgezal_link: got %b/%0d want 1/31", lwe1, lr1); end
        n_tests++; if (ld1 !== 32'h208) begin n_fail++; $display("FAIL bgezal_data: got %h want 208", ld1); end
        n_tests++; if (bz1 !== 1'b0) begin n_fail++; $display("FAIL bgezal_busy: got %b want 0", bz1); end
        ev = 2'b00;
        tick();
        n_tests++; if ({lwe1, bz1} !== 2'b00) begin n_fail++; $display("FAIL bgezal_pulse: got %b want 00", {lwe1, bz1}); end
    endtask

    task automatic test_jalr();
        do_reset();
        instr = enc_r(5'd7, 6'h09); pc = 32'h300; rs_val = 32'h4000;
        ev = 2'b10;
        tick();
        n_tests++; if ({lwe3, lr3} !== {1'b1, 5'd7}) begin n_fail++; $display("FAIL jalr_link: got %b/%0d want 1/7", lwe3, lr3); end
        n_tests++; if (ld3 !== 32'h310) begin n_fail++; $display("FAIL jalr_data: got %h want 310", ld3); end
        n_tests++; if (bz3 !== 1'b1) begin n_fail++; $display("FAIL jalr_busy: got %b want 1", bz3); end
        ev = 2'b00;
        for (int i = 0; i < 3; i++) begin
            slot_retire = 1'b1;
            tick();
            n_tests++; if (rv3 !== (i == 2)) begin n_fail++; $display("FAIL jalr_slot%0d: got %b want %b", i, rv3, i == 2); end
            slot_retire = 1'b0;
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            n_tests++; if ({rv3, tg3} !== {1'b1, 32'h4000}) begin n_fail++; $display("FAIL jalr_hold%0d: got %b/%h want 1/4000", i, rv3, tg3); end
        end
        redirect_ready = 1'b1;
        tick();
        n_tests++; if ({rv3, bz3} !== 2'b00) begin n_fail++; $display("FAIL jalr_release: got %b want 00", {rv3, bz3}); end
        redirect_ready = 1'b0;
    endtask

    task automatic test_nested();
        do_reset();
        instr = enc_i(6'h05, 5'd2, 16'hFFFE); pc = 32'h1000; rs_val = 1; rt_val = 2;
        ev = 2'b01;
        tick();
        instr = enc_j(6'h02, 26'h123456);
        tick();
        n_tests++; if ({ne1, lwe1, bz1} !== 3'b101) begin n_fail++; $display("FAIL nested_pulse: got %b want 101", {ne1, lwe1, bz1}); end
        ev = 2'b00;
        tick();
        n_tests++; if (ne1 !== 1'b0) begin n_fail++; $display("FAIL nested_once: got %b want 0", ne1); end
        slot_retire = 1'b1;
        tick();
        n_tests++; if ({rv1, tg1} !== {1'b1, 32'hFFC}) begin n_fail++; $display("FAIL nested_target: got %b/%h want 1/ffc", rv1, tg1); end
        slot_retire = 1'b0; redirect_ready = 1'b1;
        instr = enc_j(6'h03, 26'h000100); ev = 2'b01;   // arrives on the handshake edge
        tick();
        n_tests++; if ({rv1, bz1, ne1, lwe1} !== 4'b0010) begin n_fail++; $display("FAIL handshake_branch: got %b want 0010", {rv1, bz1, ne1, lwe1}); end
        ev = 2'b00; redirect_ready = 1'b0;
        tick();
        n_tests++; if (bz1 !== 1'b0) begin n_fail++; $display("FAIL handshake_ignored: got %b want 0", bz1); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        instr = enc_j(6'h02, 26'h40); pc = 32'h2000;
        ev = 2'b01;
        tick();
        ev = 2'b00; slot_retire = 1'b1;
        tick();
        slot_retire = 1'b0;
        tick();
        n_tests++; if ({rv1, tg1} !== {1'b1, 32'h100}) begin n_fail++; $display("FAIL mid_redirect: got %b/%h want 1/100", rv1, tg1); end
        reset_n = 1'b0;
        #1;
        n_tests++; if ({rv1, bz1} !== 2'b00) begin n_fail++; $display("FAIL mid_async: got %b want 00", {rv1, bz1}); end
        tick();
        reset_n = 1'b1;
        instr = enc_r(5'd3, 6'h21); ev = 2'b01;
        tick();
        n_tests++; if (ov1 !== 74'd0) begin n_fail++; $display("FAIL mid_nonbranch: got %h want 0", ov1); end
        ev = 2'b00;
    endtask

    task automatic test_likely();
        do_reset();
        instr = enc_i(6'h15, 5'd2, 16'h0020); pc = 32'h400; rs_val = 3; rt_val = 3;
        ev = 2'b01;
        tick();
        n_tests++; if ({an1, bz1, rv1, lwe1} !== {LIKELY_EN, 3'b000}) begin n_fail++; $display("FAIL bnel: got %b want %b000", {an1, bz1, rv1, lwe1}, LIKELY_EN); end
        ev = 2'b00;
        tick();
        n_tests++; if ({an1, bz1} !== 2'b00) begin n_fail++; $display("FAIL bnel_pulse: got %b want 00", {an1, bz1}); end
    endtask

    // reference decode straight from the ISA tables, using field bit patterns
    function automatic void ref_decode(input logic [31:0] w, input logic [31:0] a, input logic [31:0] b,
                                       input logic [31:0] p, output bit isbr, output bit taken,
                                       output bit link, output bit likely, output logic [4:0] lr,
                                       output logic [31:0] tgt);
        logic [5:0]  op  = w[31:26];
        logic [4:0]  rtf = w[20:16];
        logic [5:0]  fn  = w[5:0];
        int signed   sa  = a;
        int signed   sb  = b;
        logic [31:0] seq = p + 32'd4;
        isbr = 0; taken = 0; link = 0; likely = 0; lr = 5'd31;
        tgt = seq + 32'(int'($signed(w[15:0])) * 4);
        if (op == 6'h02 || op == 6'h03) begin
            isbr = 1; taken = 1; link = (op == 6'h03);
            tgt = (seq & 32'hF000_0000) | {4'b0, w[25:0], 2'b00};
        end else if (op == 6'h00 && (fn == 6'h08 || fn == 6'h09)) begin
            isbr = 1; taken = 1; tgt = a;
            if (fn == 6'h09) begin link = 1; lr = w[15:11]; end
        end else if ((op >= 6'h04 && op <= 6'h07) || (LIKELY_EN && op >= 6'h14 && op <= 6'h17)) begin
            isbr = 1; likely = op[4];
            case (op[1:0])
                2'd0: taken = (sa == sb);
                2'd1: taken = (sa != sb);
                2'd2: taken = (sa <= 0);
                default: taken = (sa > 0);
            endcase
        end else if (op == 6'h01 && (rtf inside {5'h00, 5'h01, 5'h10, 5'h11} ||
                                     (LIKELY_EN && rtf inside {5'h02, 5'h03, 5'h12, 5'h13}))) begin
            isbr = 1; likely = rtf[1]; link = rtf[4];
            taken = rtf[0] ? (sa >= 0) : (sa < 0);
        end
    endfunction

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'd5;
            4: return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [31:0] rnd_instr();
        logic [31:0] w = $urandom;
        logic [4:0]  rts [9] = '{5'h00, 5'h01, 5'h10, 5'h11, 5'h02, 5'h03, 5'h12, 5'h13, 5'h04};
        case ($urandom_range(0, 7))
            0: w[31:26] = $urandom_range(0, 1) ? 6'h02 : 6'h03;
            1: begin w[31:26] = 6'h00; w[5:0] = $urandom_range(0, 1) ? 6'h08 : 6'h09; end
            2: w[31:26] = 6'($urandom_range(4, 7));
            3: begin w[31:26] = 6'h01; w[20:16] = rts[$urandom_range(0, 8)]; end
            4: w[31:26] = 6'($urandom_range(20, 23));
            default: ;
        endcase
        return w;
    endfunction

    task automatic test_random();
        bit          m_busy [2], m_rv [2], m_lwe [2], m_ne [2], m_an [2];
        int          m_left [2];
        logic [31:0] m_tgt [2], m_ld [2];
        logic [4:0]  m_lr [2];
        bit isbr, taken, link, likely;
        logic [4:0]  lr;
        logic [31:0] tgt;
        logic [73:0] exp_v, got_v;
        do_reset();
        for (int k = 0; k < 2; k++) begin
            m_busy[k] = 0; m_rv[k] = 0; m_lwe[k] = 0; m_ne[k] = 0; m_an[k] = 0;
            m_left[k] = 0; m_tgt[k] = 0; m_ld[k] = 0; m_lr[k] = 0;
        end
        for (int c = 0; c < 800; c++) begin
            instr = rnd_instr(); pc = $urandom & 32'hFFFF_FFFC;
            rs_val = rnd_val(); rt_val = rnd_val();
            ev = {($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0)};
            slot_retire = $urandom_range(0, 1); redirect_ready = $urandom_range(0, 1);
            ref_decode(instr, rs_val, rt_val, pc, isbr, taken, link, likely, lr, tgt);
            for (int k = 0; k < 2; k++) begin
                int ds = (k == 0) ? 1 : 3;
                m_lwe[k] = 0; m_ne[k] = 0; m_an[k] = 0;
                if (!m_busy[k]) begin
                    if (ev[k] && isbr) begin
                        if (link) begin m_lwe[k] = 1; m_lr[k] = lr; m_ld[k] = pc + 32'(4 * (ds + 1)); end
                        if (taken) begin m_busy[k] = 1; m_left[k] = ds; m_tgt[k] = tgt; end
                        else if (likely) m_an[k] = 1;
                    end
                end else begin
                    if (ev[k] && isbr) m_ne[k] = 1;
                    if (m_rv[k]) begin
                        if (redirect_ready) begin m_rv[k] = 0; m_busy[k] = 0; end
                    end else if (slot_retire) begin
                        m_left[k]--;
                        if (m_left[k] == 0) m_rv[k] = 1;
                    end
                end
            end
            tick();
            for (int k = 0; k < 2; k++) begin
                exp_v = {m_rv[k], m_tgt[k], m_lwe[k], m_lr[k], m_ld[k], m_busy[k], m_ne[k], m_an[k]};
                got_v = (k == 0) ? ov1 : ov3;
                n_tests++;
                if (got_v !== exp_v) begin
                    n_fail++;
                    $display("FAIL random_c%0d_dut%0d: got %h want %h", c, k, got_v, exp_v);
                end
            end
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_beq();
        test_bgezal();
        test_jalr();
        test_nested();
        test_reset_mid();
        test_likely();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
